inst_fetch_unit: RTL and testbench

//  Fetch stage sitting directly upstream of the core's decode/execute: issues word reads to

---
 rtl/ifu_pkg.sv | 25 ++
 rtl/inst_fetch_unit_if.sv | 32 +++
 rtl/ifu_fifo.sv | 62 ++++++
 rtl/inst_fetch_unit.sv | 128 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ifu_pkg.sv
// ============================================================================
// Module : ifu_pkg
// Brief  : Shared types and constants for the instruction fetch unit.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package ifu_pkg;

    localparam int INST_BYTES = 4;

    typedef enum logic [0:0] {
        IFU_STATE_RUN   = 1'b0,
        IFU_STATE_DRAIN = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_unit_if.sv
// ============================================================================
// Module : ifu_mem_if / ifu_core_if
// Brief  : Instruction-memory bus and core-side fetch/redirect bus.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface ifu_mem_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_gnt, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_gnt, imem_rvalid, imem_rdata);
endinterface

interface ifu_core_if;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_val;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (output inst_valid, inst_pc, inst_val, input inst_ready, redirect, redirect_pc);
    modport slave  (input inst_valid, inst_pc, inst_val, output inst_ready, redirect, redirect_pc);
endinterface

`default_nettype wire

// File: rtl/ifu_fifo.sv
// ============================================================================
// Module : ifu_fifo
// Brief  : Synchronous prefetch FIFO of fetch entries with flush; pointers
//          carry an extra wrap bit to tell full from empty.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   push,
    input  wire fetch_entry_t           wr_data,
    input  wire logic                   pop,
    input  wire logic                   flush,
    output fetch_entry_t                rd_data,
    output logic                        empty,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int c_addr_w = $clog2(DEPTH);

    logic [c_addr_w:0] r_wptr;
    logic [c_addr_w:0] r_rptr;
    fetch_entry_t      r_mem [DEPTH];
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    assign empty   = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_addr_w] != r_rptr[c_addr_w]) &&
                     (r_wptr[c_addr_w-1:0] == r_rptr[c_addr_w-1:0]);
    assign count   = r_wptr - r_rptr;
    assign rd_data = r_mem[r_rptr[c_addr_w-1:0]];
    assign w_push  = push & ~w_full & ~flush;
    assign w_pop   = pop & ~empty & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[c_addr_w-1:0]] <= wr_data;
    end

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// ============================================================================
// Module : inst_fetch_unit
// Brief  : Prefetching instruction fetch stage with redirect/drain handling.
//          Define IFU_BYPASS_EN to forward responses straight to the core
//          when the prefetch FIFO is empty.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module inst_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    ifu_mem_if.master   mem,
    ifu_core_if.master  core
);

    localparam int            c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w:0] c_depth = (c_cnt_w + 1)'(DEPTH);

    ifu_state_e         r_state;
    ifu_state_e         w_state_next;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_resp_pc;
    logic [c_cnt_w-1:0] r_outstanding;
    logic [c_cnt_w-1:0] r_drop;
    logic [c_cnt_w-1:0] w_out_next;
    logic [c_cnt_w-1:0] w_fifo_count;
    logic               w_fifo_empty;
    fetch_entry_t       w_head;
    fetch_entry_t       w_push_entry;
    logic               w_room;
    logic               w_grant;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_redirect_pc;
    logic               w_unused_bits;

    // Budget covers both buffered words and words still in flight, so a push can never overflow.
    assign w_room        = ({1'b0, w_fifo_count} + {1'b0, r_outstanding}) < c_depth;
    assign mem.imem_req  = rst_n & (r_state == IFU_STATE_RUN) & w_room;
    assign mem.imem_addr = r_fetch_pc;

    assign w_grant       = mem.imem_req & mem.imem_gnt;
    assign w_out_next    = r_outstanding + {{(c_cnt_w-1){1'b0}}, w_grant}
                                         - {{(c_cnt_w-1){1'b0}}, mem.imem_rvalid};
    assign w_accept      = mem.imem_rvalid & (r_drop == '0);
    assign w_redirect_pc = {core.redirect_pc[31:2], 2'b00};
    assign w_unused_bits = &{1'b0, core.redirect_pc[1:0]};
    assign w_push_entry  = '{pc: r_resp_pc, inst: mem.imem_rdata};
    assign w_pop         = ~w_fifo_empty & core.inst_ready;

`ifdef IFU_BYPASS_EN
    logic w_bypass;
    assign w_bypass        = w_accept & w_fifo_empty & core.inst_ready;
    assign w_push          = w_accept & ~w_bypass & ~core.redirect;
    assign core.inst_valid = ~w_fifo_empty | w_bypass;
    assign core.inst_pc    = w_bypass ? r_resp_pc       : w_head.pc;
    assign core.inst_val   = w_bypass ? mem.imem_rdata  : w_head.inst;
`else
    assign w_push          = w_accept & ~core.redirect;
    assign core.inst_valid = ~w_fifo_empty;
    assign core.inst_pc    = w_head.pc;
    assign core.inst_val   = w_head.inst;
`endif

    ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (w_push),
        .wr_data (w_push_entry),
        .pop     (w_pop),
        .flush   (core.redirect),
        .rd_data (w_head),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (core.redirect) begin
                // Everything still in flight belongs to the abandoned stream.
                r_fetch_pc <= w_redirect_pc;
                r_resp_pc  <= w_redirect_pc;
                r_drop     <= w_out_next;
            end else begin
                if (w_grant)  r_fetch_pc <= r_fetch_pc + 32'(INST_BYTES);
                if (w_accept) r_resp_pc  <= r_resp_pc + 32'(INST_BYTES);
                if (mem.imem_rvalid && (r_drop != '0)) r_drop <= r_drop - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IFU_STATE_RUN;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IFU_STATE_RUN: begin
                if (core.redirect && (w_out_next != '0)) w_state_next = IFU_STATE_DRAIN;
            end
            IFU_STATE_DRAIN: begin
                if (!core.redirect && (w_out_next == '0)) w_state_next = IFU_STATE_RUN;
            end
            default: w_state_next = IFU_STATE_RUN;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// ============================================================================
// Module : tb_inst_fetch_unit
// Brief  : Randomised memory/core environment with an in-order stream model.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_inst_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IFU_BYPASS_EN
    localparam int          EXP_FIRST = 2;
`else
    localparam int          EXP_FIRST = 3;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifu_mem_if  mem_bus ();
    ifu_core_if core_bus ();

    inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (mem_bus),
        .core  (core_bus)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { bit mark; logic [31:0] pc; logic [31:0] val; } obs_t;

    mreq_t       mq[$];
    obs_t        got[$];
    int          cyc, grants, first_tick, max_out;
    int          lat_min = 1, lat_max = 1, gnt_pct = 100, rdy_pct = 100;
    bit          rd_req = 1'b0;
    logic [31:0] rd_pc  = 32'h0;
    int          n_checks = 0, n_errors = 0;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
    endfunction

    // One clock of environment: memory model, core ready, optional redirect, observation.
    task automatic tick();
        @(negedge clk);
        mem_bus.imem_rvalid = 1'b0;
        mem_bus.imem_rdata  = 32'h0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            mem_bus.imem_rvalid = 1'b1;
            mem_bus.imem_rdata  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        mem_bus.imem_gnt = (int'($urandom_range(99)) < gnt_pct);
        if (mem_bus.imem_req && mem_bus.imem_gnt) begin
            mq.push_back('{mem_bus.imem_addr, cyc + int'($urandom_range(lat_max, lat_min))});
            grants++;
        end
        core_bus.inst_ready  = (int'($urandom_range(99)) < rdy_pct);
        core_bus.redirect    = rd_req;
        core_bus.redirect_pc = rd_pc;
        rd_req = 1'b0;
        #1;
        if (core_bus.redirect) begin
            got.push_back('{1'b1, core_bus.redirect_pc & 32'hFFFF_FFFC, 32'h0});
        end else if (core_bus.inst_valid && core_bus.inst_ready) begin
            got.push_back('{1'b0, core_bus.inst_pc, core_bus.inst_val});
            if (first_tick < 0) first_tick = cyc + 1;
        end
        if (mq.size() > max_out) max_out = mq.size();
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        mem_bus.imem_gnt = 1'b0; mem_bus.imem_rvalid = 1'b0; mem_bus.imem_rdata = 32'h0;
        core_bus.inst_ready = 1'b0; core_bus.redirect = 1'b0; core_bus.redirect_pc = 32'h0;
        rd_req = 1'b0;
        mq.delete(); got.delete();
        grants = 0; first_tick = -1; max_out = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_bus.imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b, expected 0", mem_bus.imem_req); end
        n_checks++;
        if (core_bus.inst_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b, expected 0", core_bus.inst_valid); end
        n_checks++;
        if (mem_bus.imem_addr !== RESET_PC) begin n_errors++; $display("FAIL reset_addr: got %h, expected %h", mem_bus.imem_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset();
        lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 100;
        #1;
        n_checks++;
        if (mem_bus.imem_req !== 1'b1 || mem_bus.imem_addr !== RESET_PC) begin
            n_errors++; $display("FAIL stream_first_req: got req=%b addr=%h, expected 1 %h", mem_bus.imem_req, mem_bus.imem_addr, RESET_PC);
        end
        repeat (20) tick();
        n_checks++;
        if (first_tick != EXP_FIRST) begin n_errors++; $display("FAIL stream_latency: got first valid cycle %0d, expected %0d", first_tick, EXP_FIRST); end
        n_checks++;
        if (got.size() != 20 - EXP_FIRST + 1) begin n_errors++; $display("FAIL stream_count: got %0d, expected %0d", got.size(), 20 - EXP_FIRST + 1); end
        exp = RESET_PC;
        for (int i = 0; i < got.size(); i++) begin
            n_checks++;
            if (got[i].mark || got[i].pc !== exp || got[i].val !== mem_word(exp)) begin
                n_errors++; $display("FAIL stream[%0d]: got pc=%h val=%h, expected pc=%h val=%h", i, got[i].pc, got[i].val, exp, mem_word(exp));
            end
            exp += 32'd4;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 0;
        repeat (12) tick();
        n_checks++;
        if (grants != DEPTH) begin n_errors++; $display("FAIL bp_grants: got %0d, expected %0d", grants, DEPTH); end
        n_checks++;
        if (mem_bus.imem_req !== 1'b0) begin n_errors++; $display("FAIL bp_req_low: got %b, expected 0", mem_bus.imem_req); end
        rdy_pct = 100; tick(); rdy_pct = 0;
        repeat (6) tick();
        n_checks++;
        if (grants != DEPTH + 1) begin n_errors++; $display("FAIL bp_one_more: got %0d grants, expected %0d", grants, DEPTH + 1); end
        n_checks++;
        if (got.size() != 1 || got[0].pc !== RESET_PC) begin n_errors++; $display("FAIL bp_pop: got %0d items, expected 1 with pc %h", got.size(), RESET_PC); end
    endtask

    task automatic test_drain();
        logic [31:0] exp;
        do_reset();
        lat_min = 3; lat_max = 3; gnt_pct = 100; rdy_pct = 100;
        tick(); tick();
        rd_req = 1'b1; rd_pc = 32'h100;
        tick();
        n_checks++;
        if (mq.size() != 3) begin n_errors++; $display("FAIL drain_outstanding: got %0d, expected 3", mq.size()); end
        tick();
        n_checks++;
        if (mem_bus.imem_req !== 1'b0) begin n_errors++; $display("FAIL drain_req: got %b, expected 0", mem_bus.imem_req); end
        repeat (25) tick();
        n_checks++;
        if (got.size() < 2 || got[1].pc !== 32'h100) begin
            n_errors++; $display("FAIL drain_first_pc: got %0d entries, first pc %h, expected 00000100", got.size(), (got.size() > 1) ? got[1].pc : 32'hX);
        end
        exp = RESET_PC;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i].mark) exp = got[i].pc;
            else begin
                n_checks++;
                if (got[i].pc !== exp || got[i].val !== mem_word(exp)) begin
                    n_errors++; $display("FAIL drain_stream[%0d]: got pc=%h val=%h, expected pc=%h", i, got[i].pc, got[i].val, exp);
                end
                exp += 32'd4;
            end
        end
    endtask

    task automatic test_redirect_misaligned();
        logic [31:0] exp;
        int          last_mark, bad;
        do_reset();
        lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 100;
        repeat (5) tick();
        rd_req = 1'b1; rd_pc = 32'h203; tick();
        tick();
        n_checks++;
        if (mem_bus.imem_addr !== 32'h200) begin n_errors++; $display("FAIL misaligned_addr: got %h, expected 00000200", mem_bus.imem_addr); end
        lat_min = 3; lat_max = 3;
        repeat (3) tick();
        rd_req = 1'b1; rd_pc = 32'h40; tick();
        rd_req = 1'b1; rd_pc = 32'h80; tick();
        repeat (30) tick();
        exp = RESET_PC; last_mark = -1; bad = 0;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i].mark) begin exp = got[i].pc; last_mark = i; end
            else begin
                if (got[i].pc >= 32'h40 && got[i].pc < 32'h80) bad++;
                n_checks++;
                if (got[i].pc !== exp || got[i].val !== mem_word(exp)) begin
                    n_errors++; $display("FAIL b2b_stream[%0d]: got pc=%h val=%h, expected pc=%h", i, got[i].pc, got[i].val, exp);
                end
                exp += 32'd4;
            end
        end
        n_checks++;
        if (last_mark < 0 || last_mark + 1 >= got.size() || got[last_mark + 1].pc !== 32'h80) begin
            n_errors++; $display("FAIL b2b_first_pc: mark index %0d of %0d entries, expected pc 00000080 to follow", last_mark, got.size());
        end
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL b2b_stale: got %0d items from the 0x40 stream, expected 0", bad); end
    endtask

    task automatic test_redirect_full_wrap();
        logic [31:0] exp;
        int          wrapped;
        do_reset();
        lat_min = 1; lat_max = 1; gnt_pct = 100; rdy_pct = 0;
        repeat (10) tick();
        n_checks++;
        if (core_bus.inst_valid !== 1'b1) begin n_errors++; $display("FAIL full_valid: got %b, expected 1", core_bus.inst_valid); end
        rd_req = 1'b1; rd_pc = 32'h300; tick();
        tick();
        n_checks++;
        if (core_bus.inst_valid !== 1'b0) begin n_errors++; $display("FAIL full_flush: got valid %b, expected 0", core_bus.inst_valid); end
        n_checks++;
        if (mem_bus.imem_req !== 1'b1 || mem_bus.imem_addr !== 32'h300) begin
            n_errors++; $display("FAIL full_refetch: got req=%b addr=%h, expected 1 00000300", mem_bus.imem_req, mem_bus.imem_addr);
        end
        rdy_pct = 100;
        repeat (5) tick();
        rd_req = 1'b1; rd_pc = 32'hFFFF_FFF8; tick();
        repeat (20) tick();
        exp = RESET_PC; wrapped = 0;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i].mark) exp = got[i].pc;
            else begin
                if (i > 0 && !got[i-1].mark && got[i-1].pc === 32'hFFFF_FFFC && got[i].pc === 32'h0) wrapped = 1;
                n_checks++;
                if (got[i].pc !== exp || got[i].val !== mem_word(exp)) begin
                    n_errors++; $display("FAIL wrap_stream[%0d]: got pc=%h val=%h, expected pc=%h", i, got[i].pc, got[i].val, exp);
                end
                exp += 32'd4;
            end
        end
        n_checks++;
        if (wrapped != 1) begin n_errors++; $display("FAIL wrap_seen: got %0d, expected 1 (FFFFFFFC followed by 00000000)", wrapped); end
    endtask

    task automatic test_random();
        logic [31:0] exp;
        int          delivered;
        do_reset();
        for (int t = 0; t < 600; t++) begin
            if (t % 50 == 0) begin
                lat_min = int'($urandom_range(3, 1));
                lat_max = lat_min + int'($urandom_range(3));
                gnt_pct = int'($urandom_range(100, 30));
                rdy_pct = int'($urandom_range(100, 20));
            end
            if ($urandom_range(99) < 3) begin
                rd_req = 1'b1;
                rd_pc  = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : 32'($urandom);
            end
            tick();
        end
        exp = RESET_PC; delivered = 0;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i].mark) exp = got[i].pc;
            else begin
                delivered++;
                n_checks++;
                if (got[i].pc !== exp || got[i].val !== mem_word(exp)) begin
                    n_errors++; $display("FAIL random_stream[%0d]: got pc=%h val=%h, expected pc=%h val=%h", i, got[i].pc, got[i].val, exp, mem_word(exp));
                end
                exp += 32'd4;
            end
        end
        n_checks++;
        if (max_out > DEPTH) begin n_errors++; $display("FAIL random_outstanding: got max %0d, expected <= %0d", max_out, DEPTH); end
        n_checks++;
        if (delivered < 50) begin n_errors++; $display("FAIL random_progress: got %0d delivered, expected >= 50", delivered); end
        // Asynchronous reset in the middle of a clock period, with state live.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_bus.imem_req !== 1'b0 || core_bus.inst_valid !== 1'b0 || mem_bus.imem_addr !== RESET_PC) begin
            n_errors++; $display("FAIL async_reset: got req=%b valid=%b addr=%h, expected 0 0 %h",
                                 mem_bus.imem_req, core_bus.inst_valid, mem_bus.imem_addr, RESET_PC);
        end
    endtask

    initial begin
        mem_bus.imem_gnt = 1'b0; mem_bus.imem_rvalid = 1'b0; mem_bus.imem_rdata = 32'h0;
        core_bus.inst_ready = 1'b0; core_bus.redirect = 1'b0; core_bus.redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_backpressure();
        test_drain();
        test_redirect_misaligned();
        test_redirect_full_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
